fixed_divider_result_reader: RTL and testbench
==============================================

# fixed_divider_result_reader

Readout side of the fixed-point divider front panel. Captures the 32-bit divider result when the divider flags it valid, then presents it on an 8-bit output one byte at a time. The operator steps through the bytes with the same set/unlock button lock handshake used for operand entry. It sits between `fixed_divider`'s result output and the board LEDs/7-segment byte display.

## Interface
- `RESULT_WIDTH`, default 32: width of the captured divider result; must be a multiple of 8.
- `NUM_BYTES`, default `RESULT_WIDTH/8` (4): number of displayable bytes; localparam, not overridable.
- `clock`  in  1: single system clock; all state updates on the rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `result`  in  RESULT_WIDTH: divider result; sampled only when `result_valid`=1.
- `result_valid`  in  1: single-cycle or level strobe from the divider marking `result` valid.
- `set`  in  1: step button (level); advances one byte per press.
- `unlock`  in  1: release button (level); re-arms `set` after a press.
- `out`  out  8: currently displayed result byte (registered).
- `byte_idx`  out  2: index of the displayed byte, 0 = bits [7:0] (registered).
- `showing`  out  1: high while in SHOW.
- `done`  out  1: high while in DONE, after the last byte has been stepped past.
- `lockled`  out  1: current value of the internal lock flag.

## Operation
- Registers: `snap[RESULT_WIDTH-1:0]`, `idx[1:0]`, `lock`, 2-bit `state` ∈ {IDLE, SHOW, DONE}.
- `out` = `snap[8*idx +: 8]`, registered. `byte_idx` = `idx`. `showing`/`done` are decoded from `state`.
- Lock handshake, identical to operand entry:
  - A step is taken only when `set`=1 and `lock`=0. Taking a step sets `lock`=1.
  - `unlock`=1 with no step taken clears `lock`.
  - `set` and `unlock` both 1 with `lock`=0: the step wins and `lock` becomes 1.
  - `set` and `unlock` both 1 with `lock`=1: no step is taken and `lock` clears.
- IDLE:
  - `out`=0, `idx`=0.
  - `result_valid`=1: `snap`←`result`, `idx`←0, go to SHOW.
  - A step in IDLE only sets `lock`; it has no other effect.
- SHOW:
  - A step with `idx`<NUM_BYTES-1 increments `idx`.
  - A step with `idx`=NUM_BYTES-1 goes to DONE; `idx` holds at 3 and `out` keeps the top byte.
  - `result_valid` is ignored. The snapshot is stable for the whole readout.
- DONE:
  - `result_valid`=1: recapture `result`, `idx`←0, go to SHOW. This has priority over a step in the same cycle.
  - Otherwise a step goes to IDLE.
- Reset (at any point, including mid-readout): state←IDLE, `snap`←0, `idx`←0, `lock`←0. All outputs read 0 on the cycle after reset.

## Timing
- All outputs are registered and change only on the rising edge of `clock`.
- Capture latency: `result_valid` sampled high at edge N gives, after edge N, `showing`=1, `byte_idx`=0, `out`=`result[7:0]`.
- Step latency: `set`=1 with `lock`=0 sampled at edge N gives the new `byte_idx`/`out` and `lockled`=1 after edge N.
- A held `set` produces exactly one step, however many cycles it is held. The next step requires `unlock` to be sampled high in between.
- A full readout of 4 bytes takes 4 steps: 3 steps to reach byte 3, and the 4th step asserts `done`.
- No combinational path exists from any input to any output.

## Test plan
- Reset then capture: assert `reset` 2 cycles; drive `result`=32'hDEADBEEF with `result_valid` for 1 cycle -> `out`=8'hEF, `byte_idx`=0, `showing`=1, `lockled`=0.
- Full readout: alternate `set`/`unlock` pulses -> `out` sequence EF, BE, AD, DE with `byte_idx` 0..3; a 4th `set` gives `done`=1 with `out`=8'hDE; a further set/unlock pair returns to IDLE with `out`=0.
- Held button: hold `set` 10 cycles in SHOW at `idx`=0 -> exactly one advance to `idx`=1, `lockled`=1 throughout. Without `unlock`, a second `set` press does not advance.
- Snapshot stability: in SHOW at `idx`=1 of 32'h12345678, pulse `result_valid` with `result`=32'hFFFFFFFF -> `out` stays 8'h56. In DONE, the same pulse recaptures -> `out`=8'hFF, `idx`=0.
- Simultaneous inputs: `set`=`unlock`=1 with `lock`=0 -> one advance and `lock`=1. The next cycle with both still high -> no advance and `lock`=0.
- Mid-readout reset: at `idx`=2, assert `reset` for 1 cycle -> next cycle `out`=0, `byte_idx`=0, `showing`=0, `done`=0, `lockled`=0.

Source files
------------

// File: rtl/fixed_divider_result_reader.sv
// Purpose: captures the divider result and lets the operator step through it one byte at a time.
// Latency: capture and step both take effect on the outputs one clock after the input is sampled.
// Backpressure: none. Steps are gated by the set/unlock lock handshake, and result_valid is ignored while a readout is showing.
module fixed_divider_result_reader #(
  parameter int RESULT_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid,
  input  logic                    set,
  input  logic                    unlock,
  output logic [7:0]              out,
  output logic [1:0]              byte_idx,
  output logic                    showing,
  output logic                    done,
  output logic                    lockled
);

  localparam int NUM_BYTES = RESULT_WIDTH / 8;
  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [RESULT_WIDTH-1:0] snap, snap_nxt;
  logic [1:0]              idx, idx_nxt;
  logic                    lock, lock_nxt;
  logic [7:0]              out_q, out_nxt;
  logic                    step;

  // State, snapshot, index, lock and the displayed byte all update together on the clock edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
      lock  <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      snap  <= snap_nxt;
      idx   <= idx_nxt;
      lock  <= lock_nxt;
      out_q <= out_nxt;
    end
  end

  // Next-state logic. The displayed byte is computed from the next snapshot and index so it lands on the same edge as the step
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    idx_nxt   = idx;
    out_nxt   = '0;

    // A step needs a fresh press. Unlock re-arms the button only when no step is taken this cycle
    step     = set && !lock;
    lock_nxt = lock;
    if (step) begin
      lock_nxt = 1'b1;
    end else if (unlock) begin
      lock_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (result_valid) begin
          snap_nxt  = result;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        // The snapshot is frozen for the whole readout, so result_valid is not looked at here
        if (step) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      DONE: begin
        // A new result takes priority over a step that would otherwise return to IDLE
        if (result_valid) begin
          snap_nxt  = result;
          idx_nxt   = '0;
          state_nxt = SHOW;
        end else if (step) begin
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase

    if (state_nxt != IDLE) begin
      out_nxt = snap_nxt[{idx_nxt, 3'b000} +: 8];
    end
  end

  assign out      = out_q;
  assign byte_idx = idx;
  assign showing  = (state == SHOW);
  assign done     = (state == DONE);
  assign lockled  = lock;

endmodule

// File: tb/tb_fixed_divider_result_reader.sv
module tb_fixed_divider_result_reader;

  logic        clock;
  logic        reset;
  logic [31:0] result;
  logic        result_valid;
  logic        set;
  logic        unlock;
  logic [7:0]  out;
  logic [1:0]  byte_idx;
  logic        showing;
  logic        done;
  logic        lockled;

  typedef struct packed {
    logic [7:0] out;
    logic [1:0] idx;
    logic       showing;
    logic       done;
    logic       lock;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] val;

  fixed_divider_result_reader #(.RESULT_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
    .set          (set),
    .unlock       (unlock),
    .out          (out),
    .byte_idx     (byte_idx),
    .showing      (showing),
    .done         (done),
    .lockled      (lockled)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [7:0] o, input logic [1:0] i,
                              input logic sh, input logic dn, input logic lk);
    exp_t e;
    e.out = o; e.idx = i; e.showing = sh; e.done = dn; e.lock = lk;
    return e;
  endfunction

  // Pops the oldest expectation and compares every output against it
  task automatic check(input string tag);
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty: got=%0d entries required>0", tag, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (out === e.out) else begin
        bad++; $error("FAIL %s out got=%h exp=%h", tag, out, e.out);
      end
      total++;
      assert (byte_idx === e.idx) else begin
        bad++; $error("FAIL %s byte_idx got=%0d exp=%0d", tag, byte_idx, e.idx);
      end
      total++;
      assert (showing === e.showing) else begin
        bad++; $error("FAIL %s showing got=%b exp=%b", tag, showing, e.showing);
      end
      total++;
      assert (done === e.done) else begin
        bad++; $error("FAIL %s done got=%b exp=%b", tag, done, e.done);
      end
      total++;
      assert (lockled === e.lock) else begin
        bad++; $error("FAIL %s lockled got=%b exp=%b", tag, lockled, e.lock);
      end
    end
  endtask

  // Drives one cycle of inputs, records what should appear after the edge, then checks it
  task automatic cyc(input string tag, input logic rst, input logic rv, input logic [31:0] res,
                     input logic s, input logic u, input exp_t e);
    @(negedge clock);
    reset = rst; result_valid = rv; result = res; set = s; unlock = u;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  initial begin
    reset = 1'b1; result = '0; result_valid = 1'b0; set = 1'b0; unlock = 1'b0;

    // Reset for two cycles
    cyc("reset0", 1, 0, 32'h0, 0, 0, mk(8'h00, 0, 0, 0, 0));
    cyc("reset1", 1, 0, 32'h0, 0, 0, mk(8'h00, 0, 0, 0, 0));

    // Step in IDLE only sets the lock
    cyc("idle_step",   0, 0, 32'h0, 1, 0, mk(8'h00, 0, 0, 0, 1));
    cyc("idle_unlock", 0, 0, 32'h0, 0, 1, mk(8'h00, 0, 0, 0, 0));

    // Capture and full readout
    val = 32'hDEADBEEF;
    cyc("capture", 0, 1, val, 0, 0, mk(8'hEF, 0, 1, 0, 0));
    for (int i = 1; i < 4; i++) begin
      cyc("read_set",    0, 0, 32'h0, 1, 0, mk(val[8*i +: 8], 2'(i), 1, 0, 1));
      cyc("read_unlock", 0, 0, 32'h0, 0, 1, mk(val[8*i +: 8], 2'(i), 1, 0, 0));
    end
    cyc("to_done",     0, 0, 32'h0, 1, 0, mk(8'hDE, 3, 0, 1, 1));
    cyc("done_unlock", 0, 0, 32'h0, 0, 1, mk(8'hDE, 3, 0, 1, 0));
    cyc("to_idle",     0, 0, 32'h0, 1, 0, mk(8'h00, 0, 0, 0, 1));
    cyc("idle_rearm",  0, 0, 32'h0, 0, 1, mk(8'h00, 0, 0, 0, 0));

    // Held button gives exactly one step
    cyc("cap2", 0, 1, 32'h12345678, 0, 0, mk(8'h78, 0, 1, 0, 0));
    for (int i = 0; i < 10; i++) begin
      cyc("held_set", 0, 0, 32'h0, 1, 0, mk(8'h56, 1, 1, 0, 1));
    end
    cyc("release",     0, 0, 32'h0, 0, 0, mk(8'h56, 1, 1, 0, 1));
    cyc("repress_lck", 0, 0, 32'h0, 1, 0, mk(8'h56, 1, 1, 0, 1));

    // Snapshot stays frozen in SHOW
    cyc("show_ignore_rv", 0, 1, 32'hFFFFFFFF, 0, 0, mk(8'h56, 1, 1, 0, 1));
    cyc("show_unlock",    0, 0, 32'h0, 0, 1, mk(8'h56, 1, 1, 0, 0));

    // Simultaneous set and unlock
    cyc("both_unlocked", 0, 0, 32'h0, 1, 1, mk(8'h34, 2, 1, 0, 1));
    cyc("both_locked",   0, 0, 32'h0, 1, 1, mk(8'h34, 2, 1, 0, 0));

    // Mid-readout reset at idx 2
    cyc("mid_reset", 1, 0, 32'h0, 0, 0, mk(8'h00, 0, 0, 0, 0));
    cyc("post_reset", 0, 0, 32'h0, 0, 0, mk(8'h00, 0, 0, 0, 0));

    // Recapture from DONE
    cyc("cap3", 0, 1, 32'h12345678, 0, 0, mk(8'h78, 0, 1, 0, 0));
    val = 32'h12345678;
    for (int i = 1; i < 4; i++) begin
      cyc("r3_set",    0, 0, 32'h0, 1, 0, mk(val[8*i +: 8], 2'(i), 1, 0, 1));
      cyc("r3_unlock", 0, 0, 32'h0, 0, 1, mk(val[8*i +: 8], 2'(i), 1, 0, 0));
    end
    cyc("r3_done",      0, 0, 32'h0, 1, 0, mk(8'h12, 3, 0, 1, 1));
    cyc("r3_done_unlk", 0, 0, 32'h0, 0, 1, mk(8'h12, 3, 0, 1, 0));
    cyc("done_recap",   0, 1, 32'hFFFFFFFF, 0, 0, mk(8'hFF, 0, 1, 0, 0));
    cyc("recap_step",   0, 0, 32'h0, 1, 0, mk(8'hFF, 1, 1, 0, 1));

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain leftover got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
